// File: rtl/e203_reset_pkg.sv
// Shared definitions for the reset-request generator: FSM encoding and cause-bit layout.
package e203_reset_pkg;

    localparam int unsigned CAUSE_W   = 3;
    localparam int unsigned CAUSE_SW  = 0;
    localparam int unsigned CAUSE_WDG = 1;
    localparam int unsigned CAUSE_DBG = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_SETTLE = 2'd2
    } rst_state_e;

endpackage

// File: rtl/e203_reset_tmr.sv
// Up-counter with synchronous clear and enable; flags equality with a runtime limit.
module e203_reset_tmr #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_eq_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_eq_c = (r_cnt == i_limit);

endmodule

// File: rtl/e203_reset_req_gen.sv
// Arbitrates sw/watchdog/debug reset sources into a stretched active-low reset request,
// with a settle window, sticky cause bits and a saturating episode counter.
module e203_reset_req_gen
    import e203_reset_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_rst_req,
    input  logic               wdg_rst_req,
    input  logic               dbg_rst_req,
    input  logic               cause_clr,
    output logic               rst_req_n,
    output logic               rst_busy,
    output logic [CAUSE_W-1:0] rst_cause,
    output logic [CNT_W-1:0]   rst_count
);

    localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES - 1);

    rst_state_e         r_state;
    rst_state_e         w_state_nxt;
    logic [CAUSE_W-1:0] r_cause;
    logic [CAUSE_W-1:0] w_cause_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               r_sw_pend;
    logic               w_sw_pend_nxt;
    logic               r_rst_req_n;
    logic               r_busy;
    logic [CAUSE_W-1:0] w_src;
    logic               w_req_any;
    logic               w_lvl_any;
    logic               w_tmr_clr;
    logic               w_tmr_en;
    logic               w_tmr_eq;
    logic [CNT_W-1:0]   w_tmr_limit;

    always_comb begin
        w_src            = '0;
        w_src[CAUSE_SW]  = sw_rst_req;
        w_src[CAUSE_WDG] = wdg_rst_req;
        w_src[CAUSE_DBG] = dbg_rst_req;
    end

    assign w_req_any = |w_src;
    assign w_lvl_any = wdg_rst_req | dbg_rst_req;

    e203_reset_tmr #(
        .CNT_W (CNT_W)
    ) u_tmr (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .i_limit (w_tmr_limit),
        .o_eq_c  (w_tmr_eq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cause     <= '0;
            r_count     <= '0;
            r_sw_pend   <= 1'b0;
            r_rst_req_n <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cause     <= w_cause_nxt;
            r_count     <= w_count_nxt;
            r_sw_pend   <= w_sw_pend_nxt;
            r_rst_req_n <= (w_state_nxt != ST_ASSERT);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state, timer control and bookkeeping.
    always_comb begin
        w_state_nxt   = r_state;
        w_cause_nxt   = r_cause;
        w_count_nxt   = r_count;
        w_sw_pend_nxt = r_sw_pend;
        w_tmr_clr     = 1'b0;
        w_tmr_en      = 1'b0;
        w_tmr_limit   = HOLD_LIM;
        case (r_state)
            ST_IDLE: begin
                w_tmr_clr = 1'b1;
                if (w_req_any) begin
                    w_state_nxt = ST_ASSERT;
                    w_cause_nxt = w_src;
                    if (r_count != '1) begin
                        w_count_nxt = r_count + CNT_W'(1);
                    end
                end else if (cause_clr) begin
                    w_cause_nxt = '0;
                end
            end
            ST_ASSERT: begin
                w_tmr_en      = 1'b1;
                w_cause_nxt   = r_cause | w_src;
                w_sw_pend_nxt = r_sw_pend | sw_rst_req;
                if (w_tmr_eq) begin
                    // A pulse landing on the final hold cycle still earns a full extension.
                    w_tmr_clr     = 1'b1;
                    w_sw_pend_nxt = 1'b0;
                    if (!(w_lvl_any || r_sw_pend || sw_rst_req)) begin
                        w_state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                w_tmr_en    = 1'b1;
                w_tmr_limit = SETTLE_LIM;
                if (w_req_any) begin
                    w_state_nxt = ST_ASSERT;
                    w_cause_nxt = r_cause | w_src;
                    w_tmr_clr   = 1'b1;
                end else if (w_tmr_eq) begin
                    w_state_nxt = ST_IDLE;
                    w_tmr_clr   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tmr_clr   = 1'b1;
            end
        endcase
    end

    assign rst_req_n = r_rst_req_n;
    assign rst_busy  = r_busy;
    assign rst_cause = r_cause;
    assign rst_count = r_count;

endmodule

// File: tb/tb_e203_reset_req_gen.sv
// Self-checking bench: directed scenarios plus random traffic against a countdown-style reference model.
module tb_e203_reset_req_gen;

    localparam int unsigned HOLD   = 16;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned CW     = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sw_rst_req = 1'b0;
    logic          wdg_rst_req = 1'b0;
    logic          dbg_rst_req = 1'b0;
    logic          cause_clr = 1'b0;
    logic          rst_req_n;
    logic          rst_busy;
    logic [2:0]    rst_cause;
    logic [CW-1:0] rst_count;

    int checks = 0;
    int fails  = 0;

    // Reference model: cycles of low request still owed, settle cycles still owed.
    int       m_hold_left;
    int       m_settle_left;
    bit       m_pend;
    bit [2:0] m_cause;
    int       m_count;

    e203_reset_req_gen #(
        .HOLD_CYCLES   (HOLD),
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_rst_req  (sw_rst_req),
        .wdg_rst_req (wdg_rst_req),
        .dbg_rst_req (dbg_rst_req),
        .cause_clr   (cause_clr),
        .rst_req_n   (rst_req_n),
        .rst_busy    (rst_busy),
        .rst_cause   (rst_cause),
        .rst_count   (rst_count)
    );

    always #5 clk = ~clk;

    function automatic logic [CW+4:0] exp_vec();
        logic [CW-1:0] c;
        c = CW'(m_count);
        return {(m_hold_left == 0), (m_hold_left > 0 || m_settle_left > 0), m_cause, c};
    endfunction

    function automatic logic [CW+4:0] dut_vec();
        return {rst_req_n, rst_busy, rst_cause, rst_count};
    endfunction

    task automatic model_reset();
        m_hold_left   = 0;
        m_settle_left = 0;
        m_pend        = 1'b0;
        m_cause       = 3'b000;
        m_count       = 0;
    endtask

    task automatic model_edge();
        bit [2:0] src;
        bit       lvl;
        src = {dbg_rst_req, wdg_rst_req, sw_rst_req};
        lvl = wdg_rst_req | dbg_rst_req;
        if (m_hold_left > 0) begin
            m_cause     = m_cause | src;
            m_pend      = m_pend | sw_rst_req;
            m_hold_left = m_hold_left - 1;
            if (m_hold_left == 0) begin
                if (lvl || m_pend) m_hold_left = HOLD;
                else               m_settle_left = SETTLE;
                m_pend = 1'b0;
            end
        end else if (m_settle_left > 0) begin
            if (src != 3'b000) begin
                m_hold_left   = HOLD;
                m_settle_left = 0;
                m_cause       = m_cause | src;
            end else begin
                m_settle_left = m_settle_left - 1;
            end
        end else if (src != 3'b000) begin
            m_hold_left = HOLD;
            m_cause     = src;
            if (m_count < (1 << CW) - 1) m_count = m_count + 1;
        end else if (cause_clr) begin
            m_cause = 3'b000;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        sw_rst_req  = 1'b0;
        wdg_rst_req = 1'b0;
        dbg_rst_req = 1'b0;
        cause_clr   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== exp_vec() || dut_vec() !== {1'b1, 1'b0, 3'b000, CW'(0)}) begin
            fails++;
            $display("FAIL reset_state got %b want %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_sw_pulse();
        int lows;
        int busys;
        do_reset();
        repeat (9) step();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        lows  = (rst_req_n == 1'b0) ? 1 : 0;
        busys = (rst_busy == 1'b1) ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL sw_pulse cyc%0d got %b want %b", i, dut_vec(), exp_vec());
            end
            lows  += (rst_req_n == 1'b0) ? 1 : 0;
            busys += (rst_busy == 1'b1) ? 1 : 0;
        end
        checks++;
        if (lows != HOLD) begin
            fails++;
            $display("FAIL sw_low_width got %0d want %0d", lows, HOLD);
        end
        checks++;
        if (busys != HOLD + SETTLE) begin
            fails++;
            $display("FAIL sw_busy_width got %0d want %0d", busys, HOLD + SETTLE);
        end
        checks++;
        if (rst_cause !== 3'b001 || rst_count !== CW'(1)) begin
            fails++;
            $display("FAIL sw_cause_count got %b/%0d want 001/1", rst_cause, rst_count);
        end
    endtask

    task automatic test_wdg_level();
        int lows;
        int busys;
        do_reset();
        repeat (4) step();
        lows  = 0;
        busys = 0;
        wdg_rst_req = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (i == 40) wdg_rst_req = 1'b0;
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL wdg_level cyc%0d got %b want %b", i, dut_vec(), exp_vec());
            end
            lows  += (rst_req_n == 1'b0) ? 1 : 0;
            busys += (rst_busy == 1'b1) ? 1 : 0;
        end
        checks++;
        if (lows != 3 * HOLD || busys != 3 * HOLD + SETTLE) begin
            fails++;
            $display("FAIL wdg_widths got low=%0d busy=%0d want %0d/%0d", lows, busys, 3 * HOLD, 3 * HOLD + SETTLE);
        end
        checks++;
        if (rst_cause !== 3'b010 || rst_count !== CW'(1)) begin
            fails++;
            $display("FAIL wdg_cause_count got %b/%0d want 010/1", rst_cause, rst_count);
        end
    endtask

    task automatic test_settle_reentry();
        int lows;
        do_reset();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        repeat (HOLD) step();
        checks++;
        if (rst_req_n !== 1'b1 || rst_busy !== 1'b1) begin
            fails++;
            $display("FAIL reentry_in_settle got n=%b busy=%b want 1/1", rst_req_n, rst_busy);
        end
        dbg_rst_req = 1'b1;
        step();
        dbg_rst_req = 1'b0;
        lows = (rst_req_n == 1'b0) ? 1 : 0;
        for (int i = 0; i < 25; i++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL reentry cyc%0d got %b want %b", i, dut_vec(), exp_vec());
            end
            lows += (rst_req_n == 1'b0) ? 1 : 0;
        end
        checks++;
        if (lows != HOLD || rst_cause !== 3'b101 || rst_count !== CW'(1)) begin
            fails++;
            $display("FAIL reentry_summary got low=%0d cause=%b cnt=%0d want %0d/101/1", lows, rst_cause, rst_count, HOLD);
        end
    endtask

    task automatic test_cause_clr();
        do_reset();
        wdg_rst_req = 1'b1;
        step();
        wdg_rst_req = 1'b0;
        repeat (HOLD + SETTLE + 2) step();
        checks++;
        if (rst_cause !== 3'b010 || rst_busy !== 1'b0) begin
            fails++;
            $display("FAIL clr_pre got cause=%b busy=%b want 010/0", rst_cause, rst_busy);
        end
        cause_clr = 1'b1;
        step();
        cause_clr = 1'b0;
        checks++;
        if (rst_cause !== 3'b000 || dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL clr_idle got %b want 000", rst_cause);
        end
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        cause_clr  = 1'b1;
        repeat (5) step();
        cause_clr = 1'b0;
        checks++;
        if (rst_cause !== 3'b001 || rst_req_n !== 1'b0) begin
            fails++;
            $display("FAIL clr_in_assert got cause=%b n=%b want 001/0", rst_cause, rst_req_n);
        end
        wdg_rst_req = 1'b1;
        step();
        wdg_rst_req = 1'b0;
        repeat (3 * HOLD + SETTLE) step();
        checks++;
        if (rst_cause !== 3'b011 || rst_busy !== 1'b0) begin
            fails++;
            $display("FAIL clr_after_episode got cause=%b busy=%b want 011/0", rst_cause, rst_busy);
        end
        cause_clr  = 1'b1;
        sw_rst_req = 1'b1;
        step();
        cause_clr  = 1'b0;
        sw_rst_req = 1'b0;
        checks++;
        if (rst_cause !== 3'b001 || dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL clr_with_req got %b want 001", rst_cause);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        repeat (7) step();
        checks++;
        if (rst_req_n !== 1'b0 || rst_count !== CW'(1)) begin
            fails++;
            $display("FAIL async_pre got n=%b cnt=%0d want 0/1", rst_req_n, rst_count);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== {1'b1, 1'b0, 3'b000, CW'(0)}) begin
            fails++;
            $display("FAIL async_abort got %b want %b", dut_vec(), {1'b1, 1'b0, 3'b000, CW'(0)});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int e = 0; e < 260; e++) begin
            sw_rst_req = 1'b1;
            step();
            sw_rst_req = 1'b0;
            for (int i = 0; i < HOLD + SETTLE; i++) begin
                step();
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    fails++;
                    $display("FAIL sat ep%0d cyc%0d got %b want %b", e, i, dut_vec(), exp_vec());
                end
            end
        end
        checks++;
        if (rst_count !== CW'(255)) begin
            fails++;
            $display("FAIL sat_final got %0d want 255", rst_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            sw_rst_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 60) == 0) wdg_rst_req = ~wdg_rst_req;
            if ($urandom_range(0, 80) == 0) dbg_rst_req = ~dbg_rst_req;
            cause_clr = ($urandom_range(0, 7) == 0);
            if (i >= 3900) begin
                wdg_rst_req = 1'b0;
                dbg_rst_req = 1'b0;
                sw_rst_req  = 1'b0;
            end
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random cyc%0d got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        cause_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sw_pulse();
        test_wdg_level();
        test_settle_reentry();
        test_cause_clr();
        test_async_reset();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
